// File: rtl/freq_gate_counter_pkg.sv
// Shared definitions for the reciprocal gate counter and its downstream divider path.
// Holds the FSM state encoding, the default count width and the reference clock rate.
package freq_gate_counter_pkg;

  // Must match module_divider DATAWIDTH so the counts feed the divider unchanged.
  localparam int DATAWIDTH_DEF = 24;

  // Reference clock frequency in Hz, used downstream to scale cnt_sig / cnt_ref.
  localparam int F_REF = 100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/freq_gate_counter_if.sv
// Control/result bundle between the gate counter (slave) and its consumer (master).
interface freq_gate_counter_if
  import freq_gate_counter_pkg::*;
#(
  parameter int DATAWIDTH = DATAWIDTH_DEF
);

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [DATAWIDTH-1:0] cnt_sig;
  logic [DATAWIDTH-1:0] cnt_ref;
  logic                 overflow;
  logic                 timeout;

  modport master (
    output start,
    input  busy, done, cnt_sig, cnt_ref, overflow, timeout
  );

  modport slave (
    input  start,
    output busy, done, cnt_sig, cnt_ref, overflow, timeout
  );

endinterface

// File: rtl/freq_gate_counter_sig_sync_edge.sv
// Two-flop synchronizer followed by a registered rising-edge pulse.
// Reusable for any asynchronous level input; pulse appears 3 clk after the pin edge.
module freq_gate_counter_sig_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  // NOTE: non-blocking assignments make every stage capture its predecessor's
  // pre-edge value; blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
    end else begin
      meta   <= async_in;
      sync   <= meta;
      sync_d <= sync;
      rise   <= sync & ~sync_d;
    end
  end

endmodule

// File: rtl/freq_gate_counter.sv
// Equal-precision gate counter: counts signal periods and clk cycles over a gate
// that opens and closes on sig_in rising edges, so cnt_ref is an exact multiple of the period.
module freq_gate_counter
  import freq_gate_counter_pkg::*;
#(
  parameter int DATAWIDTH      = DATAWIDTH_DEF,
  parameter int GATE_CYCLES    = 1_000_000,
  parameter int TIMEOUT_CYCLES = 4_000_000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sig_in,
  freq_gate_counter_if.slave  bus
);

  localparam int GW = $clog2(GATE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_ARM     = ST_ARM;
  localparam logic [1:0] S_MEASURE = ST_MEASURE;
  localparam logic [1:0] S_DONE    = ST_DONE;

  localparam logic [DATAWIDTH-1:0] CNT_MAX   = '1;
  localparam logic [GW-1:0]        GATE_INIT = GW'(GATE_CYCLES);
  localparam logic [TW-1:0]        TO_LAST   = TW'(TIMEOUT_CYCLES - 1);

  logic                 sig_rise;
  logic [1:0]           state;
  logic [DATAWIDTH-1:0] sig_cnt;
  logic [DATAWIDTH-1:0] ref_cnt;
  logic [GW-1:0]        gate_cnt;
  logic [TW-1:0]        to_cnt;
  logic [DATAWIDTH-1:0] cnt_sig_q;
  logic [DATAWIDTH-1:0] cnt_ref_q;
  logic                 overflow_q;
  logic                 timeout_q;

  logic                 sig_sat;
  logic                 ref_sat;
  logic [DATAWIDTH-1:0] sig_inc;
  logic [DATAWIDTH-1:0] ref_inc;
  logic                 gate_open;
  logic                 to_expire;

  freq_gate_counter_sig_sync_edge u_sig_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (sig_in),
    .rise     (sig_rise)
  );

  // Saturating increments: a full counter holds at all-ones and raises overflow.
  assign sig_sat   = (sig_cnt == CNT_MAX);
  assign ref_sat   = (ref_cnt == CNT_MAX);
  assign sig_inc   = sig_sat ? CNT_MAX : sig_cnt + 1'b1;
  assign ref_inc   = ref_sat ? CNT_MAX : ref_cnt + 1'b1;
  assign gate_open = (gate_cnt != '0);
  // An edge in the expiry cycle wins, so expiry is qualified by the absence of sig_rise.
  assign to_expire = (to_cnt == TO_LAST) && !sig_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sig_cnt    <= '0;
      ref_cnt    <= '0;
      gate_cnt   <= '0;
      to_cnt     <= '0;
      cnt_sig_q  <= '0;
      cnt_ref_q  <= '0;
      overflow_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state      <= S_ARM;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
            to_cnt     <= '0;
          end
        end

        S_ARM: begin
          if (sig_rise) begin
            state    <= S_MEASURE;
            sig_cnt  <= '0;
            ref_cnt  <= '0;
            gate_cnt <= GATE_INIT;
            to_cnt   <= '0;
          end else if (to_expire) begin
            // No opening edge ever arrived: report empty counts.
            state     <= S_DONE;
            timeout_q <= 1'b1;
            cnt_sig_q <= '0;
            cnt_ref_q <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        S_MEASURE: begin
          if (sig_rise && !gate_open) begin
            // Closing edge: include this period and this cycle in the result.
            state     <= S_DONE;
            cnt_sig_q <= sig_inc;
            cnt_ref_q <= ref_inc;
            if (sig_sat || ref_sat) overflow_q <= 1'b1;
          end else if (to_expire) begin
            state     <= S_DONE;
            timeout_q <= 1'b1;
            cnt_sig_q <= sig_cnt;
            cnt_ref_q <= ref_cnt;
          end else begin
            ref_cnt <= ref_inc;
            if (ref_sat) overflow_q <= 1'b1;
            if (gate_open) gate_cnt <= gate_cnt - 1'b1;
            if (sig_rise) begin
              sig_cnt <= sig_inc;
              to_cnt  <= '0;
              if (sig_sat) overflow_q <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = (state == S_ARM) || (state == S_MEASURE);
  assign bus.done     = (state == S_DONE);
  assign bus.cnt_sig  = cnt_sig_q;
  assign bus.cnt_ref  = cnt_ref_q;
  assign bus.overflow = overflow_q;
  assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_freq_gate_counter.sv
// Bench for freq_gate_counter: two instances (wide/short gate, narrow/long gate) share
// one stimulus; expected counts come from the edge-timing rules applied to the rise list.
module tb_freq_gate_counter;
  import freq_gate_counter_pkg::*;

  localparam int T_TO = 500;
  localparam int WA   = 24;
  localparam int GA   = 100;
  localparam int WB   = 8;
  localparam int GB   = 300;

  typedef struct {
    longint s;
    longint r;
    bit     ovf;
    bit     to;
  } exp_t;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic sig_in = 1'b0;
  logic start  = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int gq[$];

  always #5 clk = ~clk;

  freq_gate_counter_if #(.DATAWIDTH(WA)) bus_a ();
  freq_gate_counter_if #(.DATAWIDTH(WB)) bus_b ();
  assign bus_a.start = start;
  assign bus_b.start = start;

  freq_gate_counter #(.DATAWIDTH(WA), .GATE_CYCLES(GA), .TIMEOUT_CYCLES(T_TO)) dut_a (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .bus(bus_a)
  );
  freq_gate_counter #(.DATAWIDTH(WB), .GATE_CYCLES(GB), .TIMEOUT_CYCLES(T_TO)) dut_b (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .bus(bus_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Rises at offsets 0, g0, g0+g1, ...; the gate closes on the first offset beyond g,
  // and silence longer than T_TO after any rise aborts with the counts reached so far.
  function automatic exp_t model(input int n_rise, input int gaps[$], input int g, input int w);
    exp_t   e;
    longint maxv = (longint'(1) << w) - 1;
    longint off  = 0;
    longint cnt  = 0;
    bit     closed = 1'b0;
    e.s = 0; e.r = 0; e.to = 1'b1; e.ovf = 1'b0;
    if (n_rise > 0) begin
      for (int i = 0; i < n_rise - 1; i++) begin
        if (gaps[i] > T_TO) break;
        off += gaps[i];
        cnt++;
        if (off > g) begin
          closed = 1'b1;
          break;
        end
      end
      e.s  = cnt;
      e.r  = closed ? off : off + T_TO - 1;
      e.to = !closed;
    end
    e.ovf = (e.s > maxv) || (e.r > maxv);
    if (e.s > maxv) e.s = maxv;
    if (e.r > maxv) e.r = maxv;
    return e;
  endfunction

  task automatic gen(input int n_rise, input int gaps[$]);
    repeat (2) @(negedge clk);
    for (int i = 0; i < n_rise; i++) begin
      int p;
      p = (i < n_rise - 1) ? gaps[i] : 4;
      sig_in = 1'b1;
      repeat (p / 2) @(negedge clk);
      sig_in = 1'b0;
      repeat (p - p / 2) @(negedge clk);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [63:0] s, input logic [63:0] r,
                     input logic o, input logic t);
    check({tag, ".cnt_sig"},  s, e.s);
    check({tag, ".cnt_ref"},  r, e.r);
    check({tag, ".overflow"}, 64'(o), 64'(e.ovf));
    check({tag, ".timeout"},  64'(t), 64'(e.to));
  endtask

  task automatic run(input string tag, input int n_rise, input int gaps[$], input bit poke,
                     input int lat);
    exp_t ea, eb;
    int   window;
    int   na, nb, ca;
    logic [63:0] sa, ra, sb, rb;
    logic oa, ta, ob, tb, busy_a_done, busy_b_done;
    ea = model(n_rise, gaps, GA, WA);
    eb = model(n_rise, gaps, GB, WB);
    window = T_TO + 40;
    foreach (gaps[i]) window += gaps[i];
    na = 0; nb = 0; ca = -1;
    sa = '0; ra = '0; sb = '0; rb = '0;
    oa = 1'b0; ta = 1'b0; ob = 1'b0; tb = 1'b0;
    busy_a_done = 1'b1; busy_b_done = 1'b1;

    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({tag, ".a.busy_after_start"}, 64'(bus_a.busy), 64'd1);
    check({tag, ".b.busy_after_start"}, 64'(bus_b.busy), 64'd1);

    fork
      gen(n_rise, gaps);
      for (int c = 1; c <= window; c++) begin
        @(posedge clk);
        #1;
        start = 1'b0;
        if (bus_a.done) begin
          na++;
          if (na == 1) begin
            ca = c; sa = 64'(bus_a.cnt_sig); ra = 64'(bus_a.cnt_ref);
            oa = bus_a.overflow; ta = bus_a.timeout; busy_a_done = bus_a.busy;
          end
        end
        if (bus_b.done) begin
          nb++;
          if (nb == 1) begin
            sb = 64'(bus_b.cnt_sig); rb = 64'(bus_b.cnt_ref);
            ob = bus_b.overflow; tb = bus_b.timeout; busy_b_done = bus_b.busy;
          end
        end
        if (poke && (c == 40 || bus_a.done)) start = 1'b1;
      end
    join
    start = 1'b0;

    check({tag, ".a.done_count"}, 64'(na), 64'd1);
    check({tag, ".b.done_count"}, 64'(nb), 64'd1);
    check({tag, ".a.busy_on_done"}, 64'(busy_a_done), 64'd0);
    check({tag, ".b.busy_on_done"}, 64'(busy_b_done), 64'd0);
    cmp({tag, ".a"}, ea, sa, ra, oa, ta);
    cmp({tag, ".b"}, eb, sb, rb, ob, tb);
    check({tag, ".a.idle_after"}, 64'(bus_a.busy), 64'd0);
    if (lat >= 0) check({tag, ".a.done_latency"}, 64'(ca), 64'(lat));
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".a.busy"}, 64'(bus_a.busy), 64'd0);
    check({tag, ".a.done"}, 64'(bus_a.done), 64'd0);
    check({tag, ".a.cnt_sig"}, 64'(bus_a.cnt_sig), 64'd0);
    check({tag, ".a.cnt_ref"}, 64'(bus_a.cnt_ref), 64'd0);
    check({tag, ".a.flags"}, 64'({bus_a.overflow, bus_a.timeout}), 64'd0);
    check({tag, ".b.cnt_ref"}, 64'(bus_b.cnt_ref), 64'd0);
    check({tag, ".b.flags"}, 64'({bus_b.overflow, bus_b.timeout, bus_b.busy}), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    int p;
    int sum;

    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    gq = {}; repeat (40) gq.push_back(10);
    run("p10", 41, gq, 1'b0, -1);

    gq = {}; repeat (50) gq.push_back(7);
    run("p7", 51, gq, 1'b0, -1);

    gq = {};
    run("hold_low", 0, gq, 1'b0, T_TO);

    gq = {}; repeat (8) gq.push_back(50);
    run("p50", 9, gq, 1'b0, -1);

    // Reset pulse in the middle of a measurement: outputs clear and no done follows.
    gq = {}; repeat (40) gq.push_back(10);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    nd = 0;
    fork
      gen(41, gq);
      for (int c = 1; c <= 500; c++) begin
        @(posedge clk);
        #1;
        if (c == 50) rst_n = 1'b0;
        if (c == 53) rst_n = 1'b1;
        if (c == 52) check_zero("mid_rst");
        if (bus_a.done || bus_b.done) nd++;
      end
    join
    check("mid_rst.done_count", 64'(nd), 64'd0);

    gq = {}; repeat (40) gq.push_back(10);
    run("post_rst", 41, gq, 1'b0, -1);
    run("start_poke", 41, gq, 1'b1, -1);

    gq = {T_TO};
    run("gap_eq_to", 2, gq, 1'b0, -1);
    gq = {T_TO + 1};
    run("gap_gt_to", 2, gq, 1'b0, -1);
    gq = {};
    run("one_edge", 1, gq, 1'b0, -1);

    for (int k = 0; k < 6; k++) begin
      gq = {};
      sum = 0;
      while (sum <= GB + 30) begin
        p = int'($urandom_range(40, 4));
        if (k == 5 && gq.size() == 2) p = int'($urandom_range(520, 490));
        gq.push_back(p);
        sum += p;
      end
      run($sformatf("rand%0d", k), gq.size() + 1, gq, 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/freq_gate_counter.md
Name: freq_gate_counter

Overview:
- Equal-precision (reciprocal) gate counter feeding module_divider.
- Measures an asynchronous input signal over a gate aligned to that signal's rising edges.
- Produces two counts: signal periods (cnt_sig) and reference-clock cycles (cnt_ref), plus a done pulse.
- Downstream logic scales the counts and passes them to the divider as dividend/divisor.

Parameters:
- DATAWIDTH, 24, width of both count outputs; matches divider DATAWIDTH.
- GATE_CYCLES, 1000000, minimum gate length in clk cycles; width is $clog2(GATE_CYCLES+1).
- TIMEOUT_CYCLES, 4000000, clk cycles without a sig rising edge before the measurement is aborted.

Ports:
- clk  input  1  reference clock; all logic is on its rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle request to begin a measurement.
- sig_in  input  1  measured signal, asynchronous to clk.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when result registers update.
- cnt_sig  output  DATAWIDTH  number of signal periods in the gate.
- cnt_ref  output  DATAWIDTH  number of clk cycles in the gate.
- overflow  output  1  a working counter saturated during the last measurement.
- timeout  output  1  the last measurement was aborted by TIMEOUT_CYCLES.

Behaviour:
- Reset: state IDLE; all outputs 0; working counters 0. Reset takes effect immediately, including mid-measurement. No done is issued for an interrupted measurement.
- Input path: 2-FF synchronizer, then a rising-edge detect register. sig_rise is a 1-cycle pulse 3 clk after the pin edge. Latency is fixed, so it cancels between the gate open and close edges.
- States: IDLE, ARM, MEASURE, DONE.
- IDLE: when start=1, go to ARM and clear overflow, timeout and the timeout counter. busy goes high next cycle. Result registers keep their old values.
- ARM: on sig_rise, go to MEASURE. In that cycle: working sig/ref counters ← 0, gate counter ← GATE_CYCLES, timeout counter ← 0.
- MEASURE, every cycle:
  - ref counter +1.
  - gate counter −1, saturating at 0.
  - on sig_rise: sig counter +1, timeout counter ← 0.
- Gate close: a sig_rise in a cycle where the registered gate counter is already 0.
  - In that cycle: copy sig+1 and ref+1 into cnt_sig/cnt_ref, go to DONE.
  - Result: the gate closes on the first signal edge more than GATE_CYCLES cycles after the opening edge.
  - cnt_ref equals exactly cnt_sig × signal period.
- Timeout: the timeout counter increments in ARM and MEASURE; it resets on every sig_rise. On reaching TIMEOUT_CYCLES:
  - timeout ← 1.
  - Copy current working counts to outputs (cnt_sig=0, cnt_ref=0 if still in ARM).
  - Go to DONE.
  - Downstream must not divide when timeout=1, since a divisor of 0 is possible.
- Saturation: working counters stop at all-ones and set overflow. Measurement continues to gate close.
- DONE: done=1 and busy=0 for one cycle, then IDLE.
- start while busy (ARM/MEASURE/DONE) is ignored.
- Simultaneous sig_rise and timeout expiry: sig_rise wins and the timeout counter resets.

Decomposition:
- Shared package:
  - state enum (IDLE/ARM/MEASURE/DONE).
  - DATAWIDTH default constant, shared with module_divider.
  - F_REF constant for downstream scaling.
- Sub-module sig_sync_edge: 2-FF synchronizer plus rising-edge pulse, used for sig_in. Reusable for other async inputs.

Test Plan:
- Reset mid-MEASURE with rst_n low for 3 cycles → all outputs 0, state IDLE, no done; a following start measures normally.
- GATE_CYCLES=100, sig period 10 clk, start → done once; cnt_sig=11, cnt_ref=110, overflow=0, timeout=0; busy low on the done cycle.
- GATE_CYCLES=100, sig period 7 clk → cnt_sig=15, cnt_ref=105 (first edge beyond 100 cycles).
- sig_in held low, TIMEOUT_CYCLES=500 → done 500 cycles after entering ARM (+1 for the start cycle); timeout=1, cnt_sig=0, cnt_ref=0.
- DATAWIDTH=8, GATE_CYCLES=300, sig period 50 → cnt_ref=255, overflow=1, cnt_sig=7.
- start pulsed again during MEASURE and on the done cycle → ignored; exactly one done, with results identical to the single-start run.
